control_fsm: RTL and testbench

Multi-cycle, parametrised successor to the processor's single-cycle instruction decoder. Accepts one decoded instruction at a time via a valid/ready handshake, sequences it through execute, memory-wait and write-back states, and drives datapath control strobes as one-cycle pulses. Sits between instruction fetch and the register file, ALU and data-memory port, and adds memory wait-state handling, an optional memory timeout, illegal-opcode detection and a sticky halt state.

---
 rtl/control_pkg.sv | 27 ++
 rtl/control_mem_timer.sv | 31 +++
 rtl/control_fsm.sv | 175 +++++++++++++++++
 tb/tb_control_fsm.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared opcode, write-source and state definitions for the multi-cycle control FSM.
package control_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b0001;
  localparam logic [3:0] OP_STORE  = 4'b0010;
  localparam logic [3:0] OP_JUMP   = 4'b0011;
  localparam logic [3:0] OP_EPAR   = 4'b0100;
  localparam logic [3:0] OP_BRANCH = 4'b0101;
  localparam logic [3:0] OP_CP     = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1011;

  localparam logic [1:0] WRITE_MEM = 2'b00;
  localparam logic [1:0] WRITE_IMM = 2'b01;
  localparam logic [1:0] WRITE_RES = 2'b10;
  localparam logic [1:0] WRITE_ALU = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM    = 3'd2,
    ST_WB     = 3'd3,
    ST_ERR    = 3'd4,
    ST_HALTED = 3'd5
  } state_t;

endpackage

// File: rtl/control_mem_timer.sv
// Memory wait-state counter; expired is high once MEM_TIMEOUT stalled cycles have been seen.
module control_mem_timer
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = (count_reg == CNT_W'(MEM_TIMEOUT));

  // Saturates at MEM_TIMEOUT so the width never needs to cover more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (tick && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM: IDLE -> EXEC -> [MEM -> WB] with one-cycle strobes.
// Optional memory timeout enabled by defining CONTROL_MEM_TIMEOUT_EN.
module control_fsm
  import control_pkg::*;
#(
  parameter int OPCODE_W    = 4,
  parameter int WSRC_W      = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic                format,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                sign,
  input  logic                mem_ready,
  output logic                cpin,
  output logic                cpout,
  output logic                mem_read,
  output logic                mem_write,
  output logic [WSRC_W-1:0]   write_src,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic                halt,
  output logic                illegal,
  output logic                mem_err
);

  if (WSRC_W < 2) begin : g_bad_wsrc
    $error("control_fsm: WSRC_W must be at least 2");
  end
  if (MEM_TIMEOUT < 1) begin : g_bad_timeout
    $error("control_fsm: MEM_TIMEOUT must be at least 1");
  end
  if (OPCODE_W < 4) begin : g_bad_opcode
    $error("control_fsm: OPCODE_W must hold the 4-bit opcode constants");
  end

  state_t              state_reg, state_next;
  logic                format_reg;
  logic [OPCODE_W-1:0] opcode_reg;
  logic                sign_reg;
  logic                is_load;

  assign is_load = (opcode_reg == OPCODE_W'(OP_LOAD));

`ifdef CONTROL_MEM_TIMEOUT_EN
  logic mem_clear;
  logic mem_tick;
  logic mem_expired;

  // Counter is held at zero outside MEM so every access starts a fresh budget.
  assign mem_clear = (state_reg != ST_MEM);
  assign mem_tick  = (state_reg == ST_MEM) && !mem_ready;

  control_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (mem_clear),
    .tick    (mem_tick),
    .expired (mem_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      format_reg <= 1'b0;
      opcode_reg <= '0;
      sign_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && instr_valid) begin
        format_reg <= format;
        opcode_reg <= opcode;
        sign_reg   <= sign;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    instr_ready = 1'b0;
    cpin        = 1'b0;
    cpout       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    write_src   = WSRC_W'(WRITE_IMM);
    reg_write   = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    halt        = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_next = ST_IDLE;
        if (!format_reg) begin
          reg_write = 1'b1;
          write_src = WSRC_W'(WRITE_IMM);
        end else begin
          case (opcode_reg)
            OPCODE_W'(OP_ADD), OPCODE_W'(OP_EPAR): begin
              reg_write = 1'b1;
              write_src = WSRC_W'(WRITE_ALU);
            end
            OPCODE_W'(OP_CP): begin
              if (sign_reg) begin
                cpout = 1'b1;
              end else begin
                cpin      = 1'b1;
                reg_write = 1'b1;
                write_src = WSRC_W'(WRITE_RES);
              end
            end
            OPCODE_W'(OP_BRANCH): branch = 1'b1;
            OPCODE_W'(OP_JUMP):   jump   = 1'b1;
            OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE): state_next = ST_MEM;
            OPCODE_W'(OP_HALT):   state_next = ST_HALTED;
            default:              illegal = 1'b1;
          endcase
        end
      end

      ST_MEM: begin
        // Only LOAD and STORE reach MEM, so "not LOAD" means STORE.
        mem_read  = is_load;
        mem_write = !is_load;
        if (mem_ready) begin
          state_next = is_load ? ST_WB : ST_IDLE;
        end else begin
`ifdef CONTROL_MEM_TIMEOUT_EN
          if (mem_expired) begin
            state_next = ST_ERR;
          end
`endif
        end
      end

      ST_WB: begin
        reg_write  = 1'b1;
        write_src  = WSRC_W'(WRITE_MEM);
        state_next = ST_IDLE;
      end

      ST_ERR: begin
`ifdef CONTROL_MEM_TIMEOUT_EN
        mem_err = 1'b1;
`endif
        state_next = ST_IDLE;
      end

      ST_HALTED: begin
        halt = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_fsm.sv
// Directed self-checking bench for control_fsm; timeout scenario runs when CONTROL_MEM_TIMEOUT_EN is defined.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic       format;
  logic [3:0] opcode;
  logic       sign;
  logic       mem_ready;
  logic       cpin, cpout, mem_read, mem_write, reg_write;
  logic       branch, jump, halt, illegal, mem_err;
  logic [1:0] write_src;

  int checks = 0;
  int errors = 0;

  // Observed vector: {instr_ready, write_src[1:0], cpin, cpout, mem_read, mem_write,
  //                   reg_write, branch, jump, halt, illegal, mem_err}
  logic [12:0] obs;
  assign obs = {instr_ready, write_src, cpin, cpout, mem_read, mem_write,
                reg_write, branch, jump, halt, illegal, mem_err};

  localparam logic [12:0] V_IDLE     = 13'b1_01_0000000000;
  localparam logic [12:0] V_BUSY     = 13'b0_01_0000000000;
  localparam logic [12:0] V_ALU      = 13'b0_11_0000100000;
  localparam logic [12:0] V_IMM      = 13'b0_01_0000100000;
  localparam logic [12:0] V_CPIN     = 13'b0_10_1000100000;
  localparam logic [12:0] V_CPOUT    = 13'b0_01_0100000000;
  localparam logic [12:0] V_BRANCH   = 13'b0_01_0000010000;
  localparam logic [12:0] V_JUMP     = 13'b0_01_0000001000;
  localparam logic [12:0] V_LOADMEM  = 13'b0_01_0010000000;
  localparam logic [12:0] V_STOREMEM = 13'b0_01_0001000000;
  localparam logic [12:0] V_WB       = 13'b0_00_0000100000;
  localparam logic [12:0] V_ERR      = 13'b0_01_0000000001;
  localparam logic [12:0] V_HALTED   = 13'b0_01_0000000100;
  localparam logic [12:0] V_ILLEGAL  = 13'b0_01_0000000010;

  always #5 clk = ~clk;

  control_fsm #(
    .OPCODE_W    (4),
    .WSRC_W      (2),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .format      (format),
    .opcode      (opcode),
    .sign        (sign),
    .mem_ready   (mem_ready),
    .cpin        (cpin),
    .cpout       (cpout),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .write_src   (write_src),
    .reg_write   (reg_write),
    .branch      (branch),
    .jump        (jump),
    .halt        (halt),
    .illegal     (illegal),
    .mem_err     (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction in IDLE; returns 1ns into the EXEC cycle.
  task automatic send(input logic f, input logic [3:0] op, input logic s);
    format      = f;
    opcode      = op;
    sign        = s;
    instr_valid = 1'b1;
    $display("txn t=%0t format=%0b opcode=%b sign=%0b", $time, f, op, s);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; format = 1'b0; opcode = 4'b0000;
    sign = 1'b0; mem_ready = 1'b0;
    #12;
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", obs, V_IDLE);
    end
    instr_valid = 1'b1; format = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL reset_hold: got %b expected %b", obs, V_IDLE);
    end
    instr_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    send(1'b1, 4'b0000, 1'b0);
    checks++;
    if (obs !== V_ALU) begin
      errors++; $display("FAIL add_exec: got %b expected %b", obs, V_ALU);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL add_ready_again: got %b expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_imm_cp();
    // HALT opcode with format 0 must still be an immediate write.
    send(1'b0, 4'b1011, 1'b0);
    checks++;
    if (obs !== V_IMM) begin
      errors++; $display("FAIL imm_exec: got %b expected %b", obs, V_IMM);
    end
    tick();
    send(1'b1, 4'b0111, 1'b0);
    checks++;
    if (obs !== V_CPIN) begin
      errors++; $display("FAIL cp_in: got %b expected %b", obs, V_CPIN);
    end
    tick();
    send(1'b1, 4'b0111, 1'b1);
    checks++;
    if (obs !== V_CPOUT) begin
      errors++; $display("FAIL cp_out: got %b expected %b", obs, V_CPOUT);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL cp_done: got %b expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_branch_jump();
    send(1'b1, 4'b0101, 1'b0);
    checks++;
    if (obs !== V_BRANCH) begin
      errors++; $display("FAIL branch: got %b expected %b", obs, V_BRANCH);
    end
    tick();
    send(1'b1, 4'b0011, 1'b0);
    checks++;
    if (obs !== V_JUMP) begin
      errors++; $display("FAIL jump: got %b expected %b", obs, V_JUMP);
    end
    tick();
    send(1'b1, 4'b0100, 1'b0);
    checks++;
    if (obs !== V_ALU) begin
      errors++; $display("FAIL epar: got %b expected %b", obs, V_ALU);
    end
    tick();
  endtask

  task automatic test_load_store();
    int n;
    int bad;
    mem_ready = 1'b1;
    send(1'b1, 4'b0001, 1'b0);
    checks++;
    if (obs !== V_BUSY) begin
      errors++; $display("FAIL load_exec: got %b expected %b", obs, V_BUSY);
    end
    mem_ready = 1'b0;
    tick();
    n = 0; bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_read) break;
      n++;
      if (obs !== V_LOADMEM) bad++;
      mem_ready = (n >= 4);
      tick();
    end
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL load_mem_cycles: got %0d expected %0d", n, 4);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL load_mem_outputs: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (obs !== V_WB) begin
      errors++; $display("FAIL load_wb: got %b expected %b", obs, V_WB);
    end
    mem_ready = 1'b0;
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL load_done: got %b expected %b", obs, V_IDLE);
    end
    mem_ready = 1'b1;
    send(1'b1, 4'b0010, 1'b0);
    tick();
    checks++;
    if (obs !== V_STOREMEM) begin
      errors++; $display("FAIL store_mem: got %b expected %b", obs, V_STOREMEM);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL store_done: got %b expected %b", obs, V_IDLE);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_mem_wait();
    int n;
    int bad;
`ifdef CONTROL_MEM_TIMEOUT_EN
    mem_ready = 1'b0;
    send(1'b1, 4'b0001, 1'b0);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_read) break;
      n++;
      tick();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL timeout_cycles: got %0d expected %0d", n, 5);
    end
    checks++;
    if (obs !== V_ERR) begin
      errors++; $display("FAIL timeout_err: got %b expected %b", obs, V_ERR);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL timeout_idle: got %b expected %b", obs, V_IDLE);
    end
    send(1'b1, 4'b0001, 1'b0);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_read) break;
      n++;
      mem_ready = (n >= 5);
      tick();
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL timeout_edge_cycles: got %0d expected %0d", n, 5);
    end
    checks++;
    if (obs !== V_WB) begin
      errors++; $display("FAIL timeout_edge_wb: got %b expected %b", obs, V_WB);
    end
    mem_ready = 1'b0;
    tick();
`else
    mem_ready = 1'b0;
    send(1'b1, 4'b0001, 1'b0);
    tick();
    bad = 0; n = 0;
    for (int i = 0; i < 30; i++) begin
      if (obs !== V_LOADMEM) bad++;
      n++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL wait_forever: got %0d bad of %0d cycles expected 0", bad, n);
    end
    mem_ready = 1'b1;
    tick();
    checks++;
    if (obs !== V_WB) begin
      errors++; $display("FAIL wait_forever_wb: got %b expected %b", obs, V_WB);
    end
    mem_ready = 1'b0;
    tick();
`endif
  endtask

  task automatic test_illegal();
    send(1'b1, 4'b1111, 1'b0);
    checks++;
    if (obs !== V_ILLEGAL) begin
      errors++; $display("FAIL illegal_1111: got %b expected %b", obs, V_ILLEGAL);
    end
    tick();
    send(1'b1, 4'b0110, 1'b0);
    checks++;
    if (obs !== V_ILLEGAL) begin
      errors++; $display("FAIL illegal_0110: got %b expected %b", obs, V_ILLEGAL);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL illegal_done: got %b expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    format = 1'b1; opcode = 4'b0000; sign = 1'b0;
    instr_valid = 1'b1;
    $display("txn t=%0t back-to-back ADD stream for 10 cycles", $time);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (reg_write) n++;
    end
    instr_valid = 1'b0;
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL b2b_count: got %0d writes expected %0d", n, 5);
    end
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL b2b_idle: got %b expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    send(1'b1, 4'b0001, 1'b0);
    tick(); tick();
    checks++;
    if (obs !== V_LOADMEM) begin
      errors++; $display("FAIL rstmid_mem: got %b expected %b", obs, V_LOADMEM);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL rstmid_async: got %b expected %b", obs, V_IDLE);
    end
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL rstmid_after: got %b expected %b", obs, V_IDLE);
    end
    tick();
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL rstmid_no_wb: got %b expected %b", obs, V_IDLE);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_halt();
    int bad;
    send(1'b1, 4'b1011, 1'b0);
    checks++;
    if (obs !== V_BUSY) begin
      errors++; $display("FAIL halt_exec: got %b expected %b", obs, V_BUSY);
    end
    tick();
    checks++;
    if (obs !== V_HALTED) begin
      errors++; $display("FAIL halt_enter: got %b expected %b", obs, V_HALTED);
    end
    format = 1'b1; opcode = 4'b0000; instr_valid = 1'b1; mem_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs !== V_HALTED) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad);
    end
    instr_valid = 1'b0; mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== V_IDLE) begin
      errors++; $display("FAIL halt_reset_exit: got %b expected %b", obs, V_IDLE);
    end
    rst_n = 1'b1;
    tick();
    send(1'b1, 4'b0000, 1'b0);
    checks++;
    if (obs !== V_ALU) begin
      errors++; $display("FAIL post_halt_add: got %b expected %b", obs, V_ALU);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_imm_cp();
    test_branch_jump();
    test_load_store();
    test_mem_wait();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
